// File: rtl/seq_divider_if.sv
// Start/done handshake bundle between the arithmetic control FSM and seq_divider.
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             divByZero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, divByZero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, divByZero
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider: one shift-and-trial-subtract per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude core plus sign fix-up).
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, stateNext;

  logic [WIDTH-1:0] dReg;
  logic [WIDTH-1:0] qReg;
  logic [WIDTH-1:0] rReg;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quotientReg;
  logic [WIDTH-1:0] remainderReg;
  logic             divByZeroReg;

  logic [WIDTH:0]   trialShift;
  logic [WIDTH:0]   trialDiff;
  logic [WIDTH-1:0] rStep;
  logic [WIDTH-1:0] qStep;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] qFinal;
  logic [WIDTH-1:0] rFinal;
  logic             zeroDiv;
  logic             lastIter;

  assign zeroDiv  = (bus.divisor == '0);
  assign lastIter = (count == LAST_ITER);

  // The partial remainder stays below the divisor, so it never needs its top bit between iterations.
  always_comb begin
    trialShift = {1'b0, rReg[WIDTH-1:0], qReg[WIDTH-1]};
    trialShift = {rReg, qReg[WIDTH-1]};
    trialDiff  = trialShift - {1'b0, dReg};
    if (!trialDiff[WIDTH]) begin
      rStep = trialDiff[WIDTH-1:0];
      qStep = {qReg[WIDTH-2:0], 1'b1};
    end else begin
      rStep = trialShift[WIDTH-1:0];
      qStep = {qReg[WIDTH-2:0], 1'b0};
    end
  end

`ifdef DIV_SIGNED_EN
  logic signA;
  logic signB;

  always_comb begin
    opA    = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    opB    = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    qFinal = (signA ^ signB) ? -qStep : qStep;
    rFinal = signA ? -rStep : rStep;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signA <= 1'b0;
      signB <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      signA <= bus.dividend[WIDTH-1];
      signB <= bus.divisor[WIDTH-1];
    end
  end
`else
  always_comb begin
    opA    = bus.dividend;
    opB    = bus.divisor;
    qFinal = qStep;
    rFinal = rStep;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          stateNext = zeroDiv ? DONE : CALC;
        end
      end
      CALC: begin
        if (lastIter) begin
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Result registers load only on entry to DONE; a zero divisor bypasses CALC entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dReg         <= '0;
      qReg         <= '0;
      rReg         <= '0;
      count        <= '0;
      quotientReg  <= '0;
      remainderReg <= '0;
      divByZeroReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dReg         <= opB;
            qReg         <= opA;
            rReg         <= '0;
            count        <= '0;
            divByZeroReg <= 1'b0;
            if (zeroDiv) begin
              quotientReg  <= '1;
              remainderReg <= bus.dividend;
              divByZeroReg <= 1'b1;
            end
          end
        end
        CALC: begin
          qReg  <= qStep;
          rReg  <= rStep;
          count <= count + 1'b1;
          if (lastIter) begin
            quotientReg  <= qFinal;
            remainderReg <= rFinal;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == CALC);
  assign bus.done      = (state == DONE);
  assign bus.quotient  = quotientReg;
  assign bus.remainder = remainderReg;
  assign bus.divByZero = divByZeroReg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed vector table plus hand-written handshake/reset sequences for seq_divider.
module tb_seq_divider;

  logic clk;
  logic rst;

  seq_divider_if #(.WIDTH(4)) bus ();

  seq_divider #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a, b, q, r;
    logic       dbz;
    int         busy;
    int         doneAt;
  } vec_t;

  vec_t vecs[8];
  int   checkCount = 0;
  int   passCount  = 0;
  bit   holdStart  = 1'b0;
  bit   scramble   = 1'b0;

  // Independent reference using native integer division (truncates toward zero).
  function automatic logic [7:0] refDiv(input logic [3:0] a, input logic [3:0] b);
    int x, y, q, r;
`ifdef DIV_SIGNED_EN
    x = int'($signed(a));
    y = int'($signed(b));
`else
    x = int'(a);
    y = int'(b);
`endif
    if (y == 0) return {4'hF, a};
    q = x / y;
    r = x % y;
    return {q[3:0], r[3:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Samples once per negedge until Done or the cycle budget runs out (doneAt stays 0).
  task automatic waitDone(output int busyCycles, output int doneAt);
    logic sawBusy, sawDone;
    busyCycles = 0;
    doneAt     = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      sawBusy = bus.busy;
      sawDone = bus.done;
      if (!holdStart) bus.start = 1'b0;
      if (scramble) begin
        bus.dividend = 4'($urandom);
        bus.divisor  = 4'($urandom);
      end
      if (sawBusy) busyCycles++;
      if (sawDone) begin
        doneAt = cyc;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               output int busyCycles, output int doneAt);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    waitDone(busyCycles, doneAt);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bc, da, doneSeen;
    logic [7:0] exp8;

`ifdef DIV_SIGNED_EN
    vecs[0] = '{4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 4, 5};
    vecs[1] = '{4'h7, 4'hE, 4'hD, 4'h1, 1'b0, 4, 5};
    vecs[2] = '{4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 4, 5};
    vecs[3] = '{4'h7, 4'h0, 4'hF, 4'h7, 1'b1, 0, 1};
    vecs[4] = '{4'hA, 4'hD, 4'h2, 4'h0, 1'b0, 4, 5};
    vecs[5] = '{4'h5, 4'h3, 4'h1, 4'h2, 1'b0, 4, 5};
    vecs[6] = '{4'hB, 4'h3, 4'hF, 4'hE, 1'b0, 4, 5};
    vecs[7] = '{4'h8, 4'h0, 4'hF, 4'h8, 1'b1, 0, 1};
`else
    vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 4, 5};
    vecs[1] = '{4'd7,  4'd0,  4'd15, 4'd7, 1'b1, 0, 1};
    vecs[2] = '{4'd3,  4'd9,  4'd0,  4'd3, 1'b0, 4, 5};
    vecs[3] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 4, 5};
    vecs[4] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 4, 5};
    vecs[5] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 4, 5};
    vecs[6] = '{4'd14, 4'd4,  4'd3,  4'd2, 1'b0, 4, 5};
    vecs[7] = '{4'd9,  4'd2,  4'd4,  4'd1, 1'b0, 4, 5};
`endif

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1;
    checkOutput("reset_outputs", {bus.busy, bus.done, bus.divByZero, bus.quotient, bus.remainder}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, bc, da);
      checkOutput($sformatf("vec%0d_quotient", i), bus.quotient, vecs[i].q);
      checkOutput($sformatf("vec%0d_remainder", i), bus.remainder, vecs[i].r);
      checkOutput($sformatf("vec%0d_divbyzero", i), bus.divByZero, vecs[i].dbz);
      checkOutput($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].busy);
      checkOutput($sformatf("vec%0d_done_at", i), da, vecs[i].doneAt);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_pulse", i), bus.done, 1'b0);
      checkOutput($sformatf("vec%0d_held", i), {bus.divByZero, bus.quotient, bus.remainder},
                  {vecs[i].dbz, vecs[i].q, vecs[i].r});
    end

    $display("[TB] asynchronous reset between edges");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs", {bus.busy, bus.done, bus.divByZero, bus.quotient, bus.remainder}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset during CALC");
    @(negedge clk);
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("midcalc_busy_before", bus.busy, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midcalc_abort", {bus.busy, bus.done}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done || bus.busy) doneSeen++;
    end
    checkOutput("midcalc_no_done", doneSeen, 0);

    $display("[TB] Start held through CALC, back-to-back restart");
    holdStart = 1'b1;
    applyStimulus(4'd15, 4'd1, bc, da);
    exp8 = refDiv(4'd15, 4'd1);
    checkOutput("hold_result", {bus.quotient, bus.remainder}, exp8);
    checkOutput("hold_timing", {bc[7:0], da[7:0]}, {8'd4, 8'd5});
    @(negedge clk);
    checkOutput("hold_single_done", {bus.done, bus.busy}, 2'b00);
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    @(negedge clk);
    checkOutput("b2b_started", bus.busy, 1'b1);
    checkOutput("b2b_held_during_calc", {bus.quotient, bus.remainder}, exp8);
    holdStart = 1'b0;
    bus.start = 1'b0;
    waitDone(bc, da);
    checkOutput("b2b_result", {bus.quotient, bus.remainder}, refDiv(4'd13, 4'd3));
    checkOutput("b2b_timing", {bc[7:0], da[7:0]}, {8'd3, 8'd4});

    $display("[TB] operands scrambled during CALC");
    scramble = 1'b1;
    applyStimulus(4'd11, 4'd2, bc, da);
    scramble = 1'b0;
    checkOutput("scramble_result", {bus.quotient, bus.remainder}, refDiv(4'd11, 4'd2));
    checkOutput("scramble_done_at", da, 5);

    $display("[TB] exhaustive sweep");
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        applyStimulus(4'(a), 4'(b), bc, da);
        checkOutput($sformatf("sweep_%0d_%0d", a, b),
                    {bc[7:0], da[7:0], 7'd0, bus.divByZero, bus.quotient, bus.remainder},
                    {8'd4, 8'd5, 8'd0, refDiv(4'(a), 4'(b))});
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
